// File: rtl/keystone_pkg.sv
// Types and constants shared by the Keystone video front-end blocks.
package keystone_pkg;

    localparam int DEF_WIDTH   = 1920;
    localparam int DEF_HEIGHT  = 1080;
    localparam int BEAT_DATA_W = 64;

    localparam int ERR_SHORT     = 0;
    localparam int ERR_LONG      = 1;
    localparam int ERR_EARLY_SOF = 2;
    localparam int ERR_ORPHAN    = 3;

    typedef enum logic [2:0] {
        WAIT_SOF,
        PASS,
        PAD_LINE,
        PAD_FRAME,
        DROP
    } sanitizer_state_t;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   user;
        logic                   last;
    } video_beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register; carries an end-of-frame tag
// alongside the beat so the top can pulse frame_done on downstream accept.
module axis_out_reg
    import keystone_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        aclken,
    input  logic        i_clr,
    input  logic        i_push,
    input  video_beat_t i_beat,
    input  logic        i_eof,
    input  logic        i_ready,
    output logic        o_valid,
    output video_beat_t o_beat,
    output logic        o_eof
);

    logic        r_valid;
    video_beat_t r_beat;
    logic        r_eof;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_eof   <= 1'b0;
        end else if (aclken) begin
            if (i_clr) begin
                r_valid <= 1'b0;
                r_beat  <= '0;
                r_eof   <= 1'b0;
            end else if (i_push) begin
                r_valid <= 1'b1;
                r_beat  <= i_beat;
                r_eof   <= i_eof;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_beat  = r_beat;
    assign o_eof   = r_eof;

endmodule

// File: rtl/video_frame_sanitizer.sv
// Forces every output frame to exactly WIDTH x HEIGHT beats with one SOF and
// one EOL per line, padding, dropping and flagging malformed input.
module video_frame_sanitizer
    import keystone_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                HEIGHT    = DEF_HEIGHT,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0,
    parameter int                CNT_W     = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              aclken,
    input  logic              SW_RESET,
    input  logic [DATA_W-1:0] s_axis_video_tdata_in,
    input  logic              s_axis_video_tvalid_in,
    output logic              s_axis_video_tready_out,
    input  logic              s_axis_video_tuser_in,
    input  logic              s_axis_video_tlast_in,
    output logic [DATA_W-1:0] s_axis_video_tdata_out,
    output logic              s_axis_video_tvalid_out,
    input  logic              s_axis_video_tready_in,
    output logic              s_axis_video_tuser_out,
    output logic              s_axis_video_tlast_out,
    output logic              frame_done,
    output logic [3:0]        err_flags,
    output logic [15:0]       frames_out
);

    sanitizer_state_t r_state;
    logic [CNT_W-1:0] r_x, r_y;
    logic [3:0]       r_err;
    logic [15:0]      r_frames;

    logic             w_valid_out, w_out_eof, w_slot_free, w_tready, w_acc;
    logic             w_at_origin, w_x_end, w_f_end, w_sof_hold;
    logic             w_fwd, w_pad, w_push, w_done;
    video_beat_t      w_in_beat, w_out_beat;
    sanitizer_state_t w_fwd_state;
    logic [3:0]       w_fwd_err;

    assign w_slot_free = !w_valid_out || s_axis_video_tready_in;
    assign w_at_origin = (r_x == '0) && (r_y == '0);
    assign w_x_end     = (r_x == CNT_W'(WIDTH - 1));
    assign w_f_end     = w_x_end && (r_y == CNT_W'(HEIGHT - 1));
    assign w_sof_hold  = s_axis_video_tvalid_in && s_axis_video_tuser_in;

    // An SOF arriving mid-frame is left on the bus until the frame is closed.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            WAIT_SOF:   w_tready = w_slot_free;
            PASS, DROP: w_tready = w_slot_free && !w_sof_hold;
            default:    w_tready = 1'b0;
        endcase
    end

    assign w_acc  = s_axis_video_tvalid_in && w_tready;
    assign w_fwd  = w_acc && ((r_state == PASS) ||
                              (r_state == WAIT_SOF && s_axis_video_tuser_in));
    assign w_pad  = ((r_state == PAD_LINE) || (r_state == PAD_FRAME)) && w_slot_free;
    assign w_push = w_fwd || w_pad;
    assign w_done = aclken && w_valid_out && s_axis_video_tready_in && w_out_eof;

    always_comb begin
        w_fwd_err   = '0;
        w_fwd_state = PASS;
        if (w_x_end && !s_axis_video_tlast_in) w_fwd_err[ERR_LONG]  = 1'b1;
        if (!w_x_end && s_axis_video_tlast_in) w_fwd_err[ERR_SHORT] = 1'b1;
        if (w_f_end)
            w_fwd_state = WAIT_SOF;
        else if (w_x_end && !s_axis_video_tlast_in)
            w_fwd_state = DROP;
        else if (!w_x_end && s_axis_video_tlast_in)
            w_fwd_state = PAD_LINE;
    end

    // Beat struct is fixed-width; tdata is sized in and out of it.
    assign w_in_beat.data = w_fwd ? BEAT_DATA_W'(s_axis_video_tdata_in)
                                  : BEAT_DATA_W'(PAD_VALUE);
    assign w_in_beat.user = w_at_origin;
    assign w_in_beat.last = w_x_end;

    axis_out_reg u_out (
        .aclk    (aclk),
        .aresetn (aresetn),
        .aclken  (aclken),
        .i_clr   (SW_RESET),
        .i_push  (w_push),
        .i_beat  (w_in_beat),
        .i_eof   (w_f_end),
        .i_ready (s_axis_video_tready_in),
        .o_valid (w_valid_out),
        .o_beat  (w_out_beat),
        .o_eof   (w_out_eof)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= WAIT_SOF;
            r_x      <= '0;
            r_y      <= '0;
            r_err    <= '0;
            r_frames <= '0;
        end else if (aclken) begin
            if (SW_RESET) begin
                r_state  <= WAIT_SOF;
                r_x      <= '0;
                r_y      <= '0;
                r_err    <= '0;
                r_frames <= '0;
            end else begin
                if (w_done) r_frames <= r_frames + 16'd1;
                if (w_push) begin
                    if (w_x_end) begin
                        r_x <= '0;
                        r_y <= (r_y == CNT_W'(HEIGHT - 1)) ? '0 : r_y + CNT_W'(1);
                    end else begin
                        r_x <= r_x + CNT_W'(1);
                    end
                end
                case (r_state)
                    WAIT_SOF: begin
                        if (w_acc && !s_axis_video_tuser_in) r_err[ERR_ORPHAN] <= 1'b1;
                        if (w_fwd) begin
                            r_state <= w_fwd_state;
                            r_err   <= r_err | w_fwd_err;
                        end
                    end
                    PASS, DROP: begin
                        if (w_sof_hold) begin
                            if (!w_at_origin) r_err[ERR_EARLY_SOF] <= 1'b1;
                            r_state <= w_at_origin ? WAIT_SOF : PAD_FRAME;
                        end else if (w_fwd) begin
                            r_state <= w_fwd_state;
                            r_err   <= r_err | w_fwd_err;
                        end else if (r_state == DROP && w_acc && s_axis_video_tlast_in) begin
                            r_state <= PASS;
                        end
                    end
                    PAD_LINE: if (w_pad && w_x_end) r_state <= w_f_end ? WAIT_SOF : PASS;
                    PAD_FRAME: if (w_pad && w_f_end) r_state <= WAIT_SOF;
                    default: r_state <= WAIT_SOF;
                endcase
            end
        end
    end

    assign s_axis_video_tready_out = w_tready;
    assign s_axis_video_tvalid_out = w_valid_out;
    assign s_axis_video_tdata_out  = DATA_W'(w_out_beat.data);
    assign s_axis_video_tuser_out  = w_out_beat.user;
    assign s_axis_video_tlast_out  = w_out_beat.last;
    assign frame_done              = w_done;
    assign err_flags               = r_err;
    assign frames_out              = r_frames;

endmodule

// File: tb/tb_video_frame_sanitizer.sv
// Scoreboard bench for video_frame_sanitizer at WIDTH=8, HEIGHT=4.
module tb_video_frame_sanitizer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken = 1'b1;
    logic          sw_reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          vin = 1'b0, uin = 1'b0, lin = 1'b0, rdy_in = 1'b1;
    logic [DW-1:0] dout;
    logic          rdy_out, vout, uout, lout, frame_done;
    logic [3:0]    err_flags;
    logic [15:0]   frames_out;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t         in_q[$];
    beat_t         exp_q[$];
    int            n_tests = 0, n_fail = 0;
    int            ex = 0, ey = 0, cyc = 0;
    int            n_done = 0, n_stall = 0, t_in = -1, t_out = -1;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    video_frame_sanitizer #(
        .DATA_W(DW), .WIDTH(W), .HEIGHT(H), .PAD_VALUE(64'h0), .CNT_W(12)
    ) dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .aclken                  (aclken),
        .SW_RESET                (sw_reset),
        .s_axis_video_tdata_in   (din),
        .s_axis_video_tvalid_in  (vin),
        .s_axis_video_tready_out (rdy_out),
        .s_axis_video_tuser_in   (uin),
        .s_axis_video_tlast_in   (lin),
        .s_axis_video_tdata_out  (dout),
        .s_axis_video_tvalid_out (vout),
        .s_axis_video_tready_in  (rdy_in),
        .s_axis_video_tuser_out  (uout),
        .s_axis_video_tlast_out  (lout),
        .frame_done              (frame_done),
        .err_flags               (err_flags),
        .frames_out              (frames_out)
    );

    always #5 aclk = ~aclk;

    function automatic logic [DW-1:0] dv(input int f, input int i);
        return {16'hA5A5, 16'(f), 32'(i + 1)};
    endfunction

    task automatic push_in(input logic [DW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        in_q.push_back(b);
    endtask

    // Reference output position: SOF at (0,0), EOL at x=W-1.
    task automatic push_exp(input logic [DW-1:0] d);
        beat_t b;
        b.d = d; b.u = (ex == 0 && ey == 0); b.l = (ex == W - 1);
        exp_q.push_back(b);
        if (ex == W - 1) begin
            ex = 0;
            ey = (ey == H - 1) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    task automatic push_pads(input int n);
        for (int i = 0; i < n; i++) push_exp('0);
    endtask

    // One input frame whose four lines have the given lengths (tlast on each line's final beat).
    task automatic add_frame(input int f, input int l0, input int l1, input int l2, input int l3);
        int lens[4];
        int k;
        lens = '{l0, l1, l2, l3};
        k = 0;
        for (int ln = 0; ln < H; ln++) begin
            for (int p = 0; p < lens[ln]; p++) begin
                push_in(dv(f, k), (ln == 0 && p == 0), (p == lens[ln] - 1));
                if (p < W) push_exp(dv(f, k));
                k++;
            end
            if (lens[ln] < W) push_pads(W - lens[ln]);
        end
    endtask

    task automatic tick(output bit acc);
        beat_t e;
        @(negedge aclk);
        if (hold_v) begin
            n_tests++;
            if (!vout || dout !== hold_d) begin
                n_fail++;
                $display("FAIL stall_stable: got v=%0b d=%h, expected v=1 d=%h", vout, dout, hold_d);
            end
        end
        if (vout && t_out < 0) t_out = cyc;
        if (vout && rdy_in) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_beat: got d=%h u=%0b l=%0b, expected no beat", dout, uout, lout);
            end else begin
                e = exp_q.pop_front();
                if ({dout, uout, lout} !== {e.d, e.u, e.l}) begin
                    n_fail++;
                    $display("FAIL out_beat: got d=%h u=%0b l=%0b, expected d=%h u=%0b l=%0b",
                             dout, uout, lout, e.d, e.u, e.l);
                end
            end
        end
        hold_v = vout && !rdy_in;
        hold_d = dout;
        if (frame_done) n_done++;
        if (vin && !rdy_out) n_stall++;
        acc = vin && rdy_out;
        if (acc && t_in < 0) t_in = cyc;
        cyc++;
        @(posedge aclk);
        #1;
    endtask

    task automatic run(input int max_acc, input bit rnd, input bit drain);
        bit a;
        int n = 0, acc_n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && acc_n < max_acc && n < 2000) begin
            vin = (in_q.size() > 0);
            if (vin) begin
                din = in_q[0].d; uin = in_q[0].u; lin = in_q[0].l;
            end
            rdy_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(a);
            if (a) begin
                void'(in_q.pop_front());
                acc_n++;
            end
            n++;
        end
        vin = 1'b0; uin = 1'b0; lin = 1'b0; rdy_in = 1'b1;
        if (n >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: in_q=%0d exp_q=%0d left, expected both empty", in_q.size(), exp_q.size());
        end
        if (drain) repeat (3) tick(a);
    endtask

    task automatic sw_rst();
        bit a;
        vin = 1'b0; sw_reset = 1'b1;
        tick(a);
        sw_reset = 1'b0;
        ex = 0; ey = 0; n_done = 0; n_stall = 0; hold_v = 1'b0; t_in = -1; t_out = -1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (vout !== 1'b0 || uout !== 1'b0 || lout !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: got v/u/l=%0b%0b%0b, expected 000", vout, uout, lout);
        end
        n_tests++;
        if (dout !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", dout); end
        n_tests++;
        if (err_flags !== 4'b0 || frames_out !== 16'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got err=%b frames=%0d done=%0b, expected 0", err_flags, frames_out, frame_done);
        end
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_clean();
        sw_rst();
        add_frame(1, 8, 8, 8, 8);
        run(1000, 1'b0, 1'b1);
        n_tests++;
        if (t_out - t_in !== 1) begin n_fail++; $display("FAIL latency: got %0d, expected 1", t_out - t_in); end
        n_tests++;
        if (err_flags !== 4'b0000) begin n_fail++; $display("FAIL clean_err: got %b, expected 0000", err_flags); end
        n_tests++;
        if (frames_out !== 16'd1 || n_done !== 1) begin
            n_fail++; $display("FAIL clean_frames: got frames=%0d done=%0d, expected 1/1", frames_out, n_done);
        end
    endtask

    task automatic test_short_line();
        sw_rst();
        add_frame(2, 8, 5, 8, 8);
        run(1000, 1'b0, 1'b1);
        n_tests++;
        if (n_stall !== 3) begin n_fail++; $display("FAIL short_stall: got %0d, expected 3", n_stall); end
        n_tests++;
        if (err_flags !== 4'b0001) begin n_fail++; $display("FAIL short_err: got %b, expected 0001", err_flags); end
        n_tests++;
        if (frames_out !== 16'd1) begin n_fail++; $display("FAIL short_frames: got %0d, expected 1", frames_out); end
    endtask

    task automatic test_long_line();
        sw_rst();
        add_frame(3, 8, 8, 11, 8);
        run(1000, 1'b0, 1'b1);
        n_tests++;
        if (err_flags !== 4'b0010) begin n_fail++; $display("FAIL long_err: got %b, expected 0010", err_flags); end
        n_tests++;
        if (frames_out !== 16'd1 || n_done !== 1) begin
            n_fail++; $display("FAIL long_frames: got frames=%0d done=%0d, expected 1/1", frames_out, n_done);
        end
    endtask

    task automatic test_early_sof();
        sw_rst();
        for (int i = 0; i < 13; i++) begin
            push_in(dv(4, i), (i == 0), (i == W - 1));
            push_exp(dv(4, i));
        end
        push_pads(19);
        add_frame(5, 8, 8, 8, 8);
        run(1000, 1'b0, 1'b1);
        n_tests++;
        if (err_flags !== 4'b0100) begin n_fail++; $display("FAIL early_err: got %b, expected 0100", err_flags); end
        n_tests++;
        if (frames_out !== 16'd2 || n_done !== 2) begin
            n_fail++; $display("FAIL early_frames: got frames=%0d done=%0d, expected 2/2", frames_out, n_done);
        end
    endtask

    task automatic test_orphan_random();
        sw_rst();
        for (int i = 0; i < 3; i++) push_in(dv(6, 100 + i), 1'b0, 1'b0);
        add_frame(7, 8, 8, 8, 8);
        run(1000, 1'b1, 1'b1);
        n_tests++;
        if (err_flags !== 4'b1000) begin n_fail++; $display("FAIL orphan_err: got %b, expected 1000", err_flags); end
        n_tests++;
        if (frames_out !== 16'd1 || n_done !== 1) begin
            n_fail++; $display("FAIL orphan_frames: got frames=%0d done=%0d, expected 1/1", frames_out, n_done);
        end
    endtask

    task automatic test_async_reset();
        sw_rst();
        add_frame(8, 8, 8, 8, 8);
        run(10, 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (vout !== 1'b0 || uout !== 1'b0 || lout !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL async_rst_out: got v=%0b u=%0b l=%0b d=%h, expected all 0", vout, uout, lout, dout);
        end
        n_tests++;
        if (frames_out !== 16'd0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_status: got frames=%0d done=%0b, expected 0", frames_out, frame_done);
        end
        in_q.delete(); exp_q.delete();
        hold_v = 1'b0; ex = 0; ey = 0;
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        n_done = 0;
        add_frame(9, 8, 8, 8, 8);
        run(1000, 1'b0, 1'b1);
        n_tests++;
        if (err_flags !== 4'b0000 || frames_out !== 16'd1 || n_done !== 1) begin
            n_fail++;
            $display("FAIL post_rst_frame: got err=%b frames=%0d done=%0d, expected 0000/1/1", err_flags, frames_out, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_short_line();
        test_long_line();
        test_early_sof();
        test_orphan_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
